// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types for the register file write-back path.
// Request bundle carries destination register and data.
package regfile_wb_arbiter_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Circular queue holding accepted multdiv write-backs.
// Caller guarantees no push when full and no pop when empty.
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    clrn,
  input  logic    push,
  input  wb_req_t pushReq,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output wb_req_t head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PW'(1);
      if (pop) rdPtr <= rdPtr + PW'(1);
      unique case ({push, pop})
        2'b10: count <= count + CW'(1);
        2'b01: count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= pushReq;
  end

  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head = mem[rdPtr];
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port:
// ALU > queued multdiv > direct multdiv, plus scoreboard.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic                alu_wr_valid,
  input  logic [REG_W-1:0]    alu_wr_reg,
  input  logic [DATA_W-1:0]   alu_wr_data,
  input  logic                md_wr_valid,
  input  logic [REG_W-1:0]    md_wr_reg,
  input  logic [DATA_W-1:0]   md_wr_data,
  output logic                md_wr_ready,
  input  logic                sb_set,
  input  logic [REG_W-1:0]    sb_reg,
  output logic [NUM_REGS-1:0] pending,
  output logic                ctrl_writeEnable,
  output logic [REG_W-1:0]    ctrl_writeReg,
  output logic [DATA_W-1:0]   data_writeReg,
  input  logic [REG_W-1:0]    rd_a_reg,
  input  logic [REG_W-1:0]    rd_b_reg,
  output logic                rd_a_hit,
  output logic                rd_b_hit,
  output logic [DATA_W-1:0]   rd_a_data,
  output logic [DATA_W-1:0]   rd_b_data,
  output logic                waw_err
);
  localparam logic [NUM_REGS-1:0] NO_R0 = ~NUM_REGS'(1);

  logic    qFull;
  logic    qEmpty;
  logic    qPush;
  logic    qPop;
  logic    mdFire;
  logic    useQ;
  logic    useMd;
  logic    issueValid;
  logic    issueMd;
  wb_req_t qHead;
  wb_req_t aluReq;
  wb_req_t mdReq;
  wb_req_t issueReq;
  logic [NUM_REGS-1:0] setMask;
  logic [NUM_REGS-1:0] clrMask;

  assign md_wr_ready = !qFull && !clrn;
  assign mdFire = md_wr_valid && md_wr_ready;
  assign aluReq = {alu_wr_reg, alu_wr_data};
  assign mdReq = {md_wr_reg, md_wr_data};
  assign useQ = !alu_wr_valid && !qEmpty;
  assign useMd = !alu_wr_valid && qEmpty && mdFire;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .clrn(clrn),
    .push(qPush),
    .pushReq(mdReq),
    .pop(qPop),
    .full(qFull),
    .empty(qEmpty),
    .head(qHead)
  );

  always_comb begin
    issueValid = 1'b0;
    issueMd = 1'b0;
    issueReq = aluReq;
    qPush = 1'b0;
    qPop = 1'b0;
    unique case (1'b1)
      alu_wr_valid: begin
        issueValid = 1'b1;
        qPush = mdFire;
      end
      useQ: begin
        issueValid = 1'b1;
        issueMd = 1'b1;
        issueReq = qHead;
        qPop = 1'b1;
        qPush = mdFire;
      end
      useMd: begin
        issueValid = 1'b1;
        issueMd = 1'b1;
        issueReq = mdReq;
      end
      default: ;
    endcase
  end

  // set beats clear when both hit the same register
  always_comb begin
    setMask = '0;
    clrMask = '0;
    if (sb_set) setMask[sb_reg] = 1'b1;
    if (issueMd) clrMask[issueReq.wreg] = 1'b1;
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
      pending <= '0;
      waw_err <= 1'b0;
    end else begin
      ctrl_writeEnable <= issueValid && issueReq.wreg != '0;
      ctrl_writeReg <= issueValid ? issueReq.wreg : '0;
      data_writeReg <= issueValid ? issueReq.data : '0;
      pending <= ((pending & ~clrMask) | setMask) & NO_R0;
      if (alu_wr_valid && alu_wr_reg != '0 && pending[alu_wr_reg])
        waw_err <= 1'b1;
    end
  end

  assign rd_a_hit = ctrl_writeEnable && ctrl_writeReg == rd_a_reg
                    && rd_a_reg != '0;
  assign rd_b_hit = ctrl_writeEnable && ctrl_writeReg == rd_b_reg
                    && rd_b_reg != '0;
  assign rd_a_data = rd_a_hit ? data_writeReg : '0;
  assign rd_b_data = rd_b_hit ? data_writeReg : '0;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table, directed
// corner sequences and random traffic against a queue model.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        clrn;
  logic        alu_wr_valid;
  logic [4:0]  alu_wr_reg;
  logic [31:0] alu_wr_data;
  logic        md_wr_valid;
  logic [4:0]  md_wr_reg;
  logic [31:0] md_wr_data;
  logic        md_wr_ready;
  logic        sb_set;
  logic [4:0]  sb_reg;
  logic [31:0] pending;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  rd_a_reg;
  logic [4:0]  rd_b_reg;
  logic        rd_a_hit;
  logic        rd_b_hit;
  logic [31:0] rd_a_data;
  logic [31:0] rd_b_data;
  logic        waw_err;

  regfile_wb_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .clrn(clrn),
    .alu_wr_valid(alu_wr_valid),
    .alu_wr_reg(alu_wr_reg),
    .alu_wr_data(alu_wr_data),
    .md_wr_valid(md_wr_valid),
    .md_wr_reg(md_wr_reg),
    .md_wr_data(md_wr_data),
    .md_wr_ready(md_wr_ready),
    .sb_set(sb_set),
    .sb_reg(sb_reg),
    .pending(pending),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .rd_a_reg(rd_a_reg),
    .rd_b_reg(rd_b_reg),
    .rd_a_hit(rd_a_hit),
    .rd_b_hit(rd_b_hit),
    .rd_a_data(rd_a_data),
    .rd_b_data(rd_b_data),
    .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  typedef struct {
    logic        av;
    logic [4:0]  ar;
    logic [31:0] ad;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic [4:0]  rda;
    logic        eWe;
    logic [4:0]  eReg;
    logic [31:0] eData;
    logic        eHit;
  } vec_t;

  ent_t        mq[$];
  bit          mPend[32];
  bit          mWaw;
  bit          mWe;
  logic [4:0]  mReg;
  logic [31:0] mData;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] packPend();
    logic [31:0] p;
    for (int i = 0; i < 32; i++) p[i] = mPend[i];
    return p;
  endfunction

  task automatic modelReset();
    mq.delete();
    for (int i = 0; i < 32; i++) mPend[i] = 1'b0;
    mWaw = 1'b0;
    mWe = 1'b0;
    mReg = '0;
    mData = '0;
  endtask

  task automatic idleIn();
    alu_wr_valid = 1'b0;
    alu_wr_reg = '0;
    alu_wr_data = '0;
    md_wr_valid = 1'b0;
    md_wr_reg = '0;
    md_wr_data = '0;
    sb_set = 1'b0;
    sb_reg = '0;
  endtask

  // one clock: predict from current inputs, clock, compare
  task automatic step();
    bit   ready;
    bit   fire;
    bit   iss;
    bit   issMd;
    bit   hitA;
    bit   hitB;
    ent_t e;
    ent_t md;
    ready = mq.size() < DEPTH;
    chk("ready_pre", md_wr_ready, ready);
    fire = md_wr_valid && ready;
    md = '{md_wr_reg, md_wr_data};
    iss = 0;
    issMd = 0;
    e = '{5'd0, 32'd0};
    if (alu_wr_valid) begin
      iss = 1;
      e = '{alu_wr_reg, alu_wr_data};
      if (fire) mq.push_back(md);
    end else if (mq.size() > 0) begin
      iss = 1;
      issMd = 1;
      e = mq.pop_front();
      if (fire) mq.push_back(md);
    end else if (fire) begin
      iss = 1;
      issMd = 1;
      e = md;
    end
    if (alu_wr_valid && alu_wr_reg != 0 && mPend[alu_wr_reg]) mWaw = 1;
    if (issMd) mPend[e.r] = 0;
    if (sb_set) mPend[sb_reg] = 1;
    mPend[0] = 0;
    mWe = iss && e.r != 0;
    mReg = e.r;
    mData = e.d;
    @(posedge clk);
    #1;
    chk("we", ctrl_writeEnable, mWe);
    if (mWe) begin
      chk("wreg", ctrl_writeReg, mReg);
      chk("wdata", data_writeReg, mData);
    end
    chk("pending", pending, packPend());
    chk("waw", waw_err, mWaw);
    chk("ready_post", md_wr_ready, mq.size() < DEPTH);
    hitA = mWe && mReg == rd_a_reg && rd_a_reg != 0;
    hitB = mWe && mReg == rd_b_reg && rd_b_reg != 0;
    chk("hit_a", rd_a_hit, hitA);
    chk("fwd_a", rd_a_data, hitA ? mData : 32'd0);
    chk("hit_b", rd_b_hit, hitB);
    chk("fwd_b", rd_b_data, hitB ? mData : 32'd0);
  endtask

  task automatic chkAllZero(input string nm);
    chk({nm, "_we"}, ctrl_writeEnable, 0);
    chk({nm, "_reg"}, ctrl_writeReg, 0);
    chk({nm, "_data"}, data_writeReg, 0);
    chk({nm, "_pend"}, pending, 0);
    chk({nm, "_waw"}, waw_err, 0);
    chk({nm, "_ready"}, md_wr_ready, 0);
    chk({nm, "_hit"}, rd_a_hit, 0);
  endtask

  vec_t tbl[8];

  initial begin
    int mdIdx;
    bit rdy;
    tbl[0] = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0, 5'd5,
               1'b1, 5'd5, 32'h1234, 1'b1};
    tbl[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5,
               1'b0, 5'd0, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB, 5'd3,
               1'b1, 5'd3, 32'hA, 1'b1};
    tbl[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd3,
               1'b1, 5'd7, 32'hB, 1'b0};
    tbl[4] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7,
               1'b0, 5'd0, 32'h0, 1'b0};
    tbl[5] = '{1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0, 5'd0,
               1'b0, 5'd0, 32'h0, 1'b0};
    tbl[6] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h66, 5'd0,
               1'b0, 5'd0, 32'h0, 1'b0};
    tbl[7] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44, 5'd4,
               1'b1, 5'd4, 32'h44, 1'b1};

    idleIn();
    rd_a_reg = '0;
    rd_b_reg = '0;
    clrn = 1'b1;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chkAllZero("reset");
    clrn = 1'b0;
    #1;
    chk("ready_after_reset", md_wr_ready, 1);

    foreach (tbl[i]) begin
      alu_wr_valid = tbl[i].av;
      alu_wr_reg = tbl[i].ar;
      alu_wr_data = tbl[i].ad;
      md_wr_valid = tbl[i].mv;
      md_wr_reg = tbl[i].mr;
      md_wr_data = tbl[i].md;
      rd_a_reg = tbl[i].rda;
      step();
      chk("tbl_we", ctrl_writeEnable, tbl[i].eWe);
      if (tbl[i].eWe) begin
        chk("tbl_reg", ctrl_writeReg, tbl[i].eReg);
        chk("tbl_data", data_writeReg, tbl[i].eData);
      end
      chk("tbl_hit", rd_a_hit, tbl[i].eHit);
      chk("tbl_fwd", rd_a_data, tbl[i].eHit ? tbl[i].eData : 32'd0);
      chk("tbl_ready", md_wr_ready, 1);
    end

    // queue fills behind continuous ALU traffic, then drains
    idleIn();
    mdIdx = 0;
    for (int c = 0; c < 6; c++) begin
      alu_wr_valid = 1'b1;
      alu_wr_reg = 5'(c + 1);
      alu_wr_data = 32'h100 + 32'(c);
      md_wr_valid = mdIdx < 5;
      md_wr_reg = 5'(10 + mdIdx);
      md_wr_data = 32'h200 + 32'(mdIdx);
      rdy = md_wr_ready;
      step();
      chk("fill_alu_reg", ctrl_writeReg, 5'(c + 1));
      if (md_wr_valid && rdy) mdIdx++;
    end
    chk("fill_accepted", mdIdx, 4);
    chk("fill_ready_low", md_wr_ready, 0);
    alu_wr_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      md_wr_valid = mdIdx < 5;
      rdy = md_wr_ready;
      step();
      chk("drain_reg", ctrl_writeReg, 5'(10 + k));
      chk("drain_data", data_writeReg, 32'h200 + 32'(k));
      if (md_wr_valid && rdy) mdIdx++;
    end
    idleIn();
    step();
    chk("drain_done_we", ctrl_writeEnable, 0);

    // r0 through the queue is dropped but still pops
    alu_wr_valid = 1'b1;
    alu_wr_reg = 5'd1;
    md_wr_valid = 1'b1;
    md_wr_reg = 5'd0;
    md_wr_data = 32'h77;
    step();
    idleIn();
    step();
    chk("r0_queue_we", ctrl_writeEnable, 0);
    md_wr_valid = 1'b1;
    md_wr_reg = 5'd6;
    md_wr_data = 32'h66;
    rd_a_reg = 5'd6;
    step();
    chk("r0_popped_direct", ctrl_writeReg, 5'd6);
    chk("r0_popped_hit", rd_a_hit, 1);

    // scoreboard and sticky WAW flag
    idleIn();
    sb_set = 1'b1;
    sb_reg = 5'd9;
    step();
    sb_set = 1'b0;
    chk("pend9_set", pending[9], 1);
    alu_wr_valid = 1'b1;
    alu_wr_reg = 5'd9;
    alu_wr_data = 32'h99;
    step();
    chk("waw_rise", waw_err, 1);
    chk("waw_alu_issued", ctrl_writeReg, 5'd9);
    idleIn();
    step();
    step();
    chk("waw_sticky", waw_err, 1);
    md_wr_valid = 1'b1;
    md_wr_reg = 5'd9;
    md_wr_data = 32'h9A;
    sb_set = 1'b1;
    sb_reg = 5'd9;
    step();
    chk("pend9_set_wins", pending[9], 1);
    sb_set = 1'b1;
    sb_reg = 5'd0;
    step();
    chk("pend9_clear", pending[9], 0);
    chk("pend0_zero", pending[0], 0);
    idleIn();

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      alu_wr_valid = ($urandom_range(0, 9) < 4);
      alu_wr_reg = 5'($urandom_range(0, 7));
      alu_wr_data = $urandom;
      md_wr_valid = ($urandom_range(0, 9) < 6);
      md_wr_reg = 5'($urandom_range(0, 7));
      md_wr_data = $urandom;
      sb_set = ($urandom_range(0, 9) < 3);
      sb_reg = 5'($urandom_range(0, 7));
      rd_a_reg = 5'($urandom_range(0, 7));
      rd_b_reg = 5'($urandom_range(0, 7));
      step();
    end

    // asynchronous reset in the middle of a drain
    idleIn();
    for (int c = 0; c < 5; c++) begin
      alu_wr_valid = 1'b1;
      alu_wr_reg = 5'd2;
      md_wr_valid = 1'b1;
      md_wr_reg = 5'(20 + c);
      sb_set = 1'b1;
      sb_reg = 5'(20 + c);
      step();
    end
    idleIn();
    step();
    chk("pre_reset_we", ctrl_writeEnable, 1);
    #2;
    clrn = 1'b1;
    #1;
    chkAllZero("mid_reset");
    @(posedge clk);
    #1;
    clrn = 1'b0;
    modelReset();
    #1;
    chk("post_reset_ready", md_wr_ready, 1);
    step();
    chk("post_reset_empty_we", ctrl_writeEnable, 0);
    md_wr_valid = 1'b1;
    md_wr_reg = 5'd11;
    md_wr_data = 32'hBEEF;
    step();
    chk("post_reset_direct", ctrl_writeReg, 5'd11);
    idleIn();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
